anode_scanner: RTL and testbench

Time-multiplexed driver for an N-digit common-anode 7-segment display. It takes a binary digit index and expands it the other way, producing a one-hot, active-low anode select together with the decoded segments for that digit. A prescaler rotates the active digit, and a short blanking interval is inserted at each digit change to prevent ghosting. The block sits between the datapath registers that hold the digit values and the board anode/segment pins.

---
 rtl/display_pkg.sv | 16 +
 rtl/anode_scanner_if.sv | 28 ++
 rtl/hex_to_sevenseg.sv | 11 +
 rtl/anode_scanner.sv | 93 +++++++++
 tb/tb_anode_scanner.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared segment types and hex-to-segment table
package display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry 15 (F) first, entry 0 last.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/anode_scanner_if.sv
// rtl/anode_scanner_if.sv - digit data in, anode/segment pins out
interface anode_scanner_if #(
    parameter int N_DIGITS = 4
);
    import display_pkg::*;

    localparam int IW = $clog2(N_DIGITS);

    logic                    enable;
    logic [4*N_DIGITS-1:0]   digits;
    logic [N_DIGITS-1:0]     dp_en;
    logic [N_DIGITS-1:0]     blank_mask;
    logic [N_DIGITS-1:0]     an_n;
    seg_t                    seg_n;
    logic                    dp_n;
    logic [IW-1:0]           idx_o;

    modport master (
        output enable, digits, dp_en, blank_mask,
        input  an_n, seg_n, dp_n, idx_o
    );

    modport slave (
        input  enable, digits, dp_en, blank_mask,
        output an_n, seg_n, dp_n, idx_o
    );

endinterface

// File: rtl/hex_to_sevenseg.sv
// rtl/hex_to_sevenseg.sv - combinational hex nibble to active-low segments
module hex_to_sevenseg
    import display_pkg::*;
(
    input  logic [3:0] hex_i,
    output seg_t       seg_o
);

    assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/anode_scanner.sv
// rtl/anode_scanner.sv - time-multiplexed common-anode 7-segment scanner
module anode_scanner
    import display_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    anode_scanner_if.slave  bus
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(N_DIGITS);

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{1'b1}};
    localparam logic [N_DIGITS-1:0] AN_ONE = {{(N_DIGITS-1){1'b0}}, 1'b1};

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [N_DIGITS-1:0] an_n_q, an_n_d;
    seg_t                seg_n_q, seg_n_d;
    logic                dp_n_q, dp_n_d;
    logic [IW-1:0]       idx_o_q, idx_o_d;

    logic [3:0]          cur_digit;
    seg_t                cur_seg;
    logic                blank;

    assign cur_digit = bus.digits[{idx_q, 2'b00} +: 4];

    hex_to_sevenseg u_dec (
        .hex_i (cur_digit),
        .seg_o (cur_seg)
    );

    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        an_n_d  = AN_OFF;
        seg_n_d = SEG_BLANK;
        dp_n_d  = 1'b1;
        idx_o_d = '0;
        blank   = (presc_q < BLANK_END) || bus.blank_mask[idx_q];

        if (!bus.enable) begin
            presc_d = '0;
            idx_d   = '0;
        end else begin
            idx_o_d = idx_q;
            if (!blank) begin
                an_n_d  = ~(AN_ONE << idx_q);
                seg_n_d = cur_seg;
                dp_n_d  = ~bus.dp_en[idx_q];
            end
            // Masked digits still run the full slot so refresh timing never shifts.
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            an_n_q  <= AN_OFF;
            seg_n_q <= SEG_BLANK;
            dp_n_q  <= 1'b1;
            idx_o_q <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_n_q  <= an_n_d;
            seg_n_q <= seg_n_d;
            dp_n_q  <= dp_n_d;
            idx_o_q <= idx_o_d;
        end
    end

    assign bus.an_n  = an_n_q;
    assign bus.seg_n = seg_n_q;
    assign bus.dp_n  = dp_n_q;
    assign bus.idx_o = idx_o_q;

endmodule

// File: tb/tb_anode_scanner.sv
// tb/tb_anode_scanner.sv - self-checking bench for anode_scanner
module tb_anode_scanner;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
    } exp_t;

    typedef struct {
        int         edge_no;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    anode_scanner_if #(.N_DIGITS(4)) bus ();

    anode_scanner #(
        .N_DIGITS     (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    exp_t sb[$];
    vec_t scan_tab[12];
    int   n_checks = 0;
    int   n_errors = 0;
    int   ecount = 0;
    int   m_presc = 0;
    int   m_idx = 0;

    task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (edge %0d): got %b expected %b", name, ecount, act, exp);
        end
    endtask

    function automatic logic [13:0] dut_out();
        return {bus.an_n, bus.seg_n, bus.dp_n, bus.idx_o};
    endfunction

    task automatic model_edge();
        exp_t e;
        logic blank;
        if (!reset_n || !bus.enable) begin
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, idx: 2'd0};
            m_presc = 0;
            m_idx   = 0;
        end else begin
            blank  = (m_presc < 2) || bus.blank_mask[m_idx];
            e.an   = blank ? 4'hF : ~(4'b0001 << m_idx);
            e.seg  = blank ? 7'h7F : hex_tab[bus.digits[m_idx*4 +: 4]];
            e.dp   = blank ? 1'b1 : ~bus.dp_en[m_idx];
            e.idx  = 2'(m_idx);
            if (m_presc == 7) begin
                m_presc = 0;
                m_idx   = (m_idx + 1) % 4;
            end else begin
                m_presc++;
            end
        end
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_edge();
        ecount++;
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("sb_empty", 14'd0, 14'd1);
        end else begin
            e = sb.pop_front();
            chk("scoreboard", dut_out(), e);
        end
    endtask

    task automatic run_to(input int n);
        while (ecount < n) tick();
    endtask

    task automatic check_at(input string name, input int n, input logic [3:0] an,
                            input logic [6:0] seg, input logic dp, input logic [1:0] idx);
        run_to(n);
        chk(name, dut_out(), {an, seg, dp, idx});
    endtask

    task automatic run_scan_table();
        foreach (scan_tab[i])
            check_at("scan", scan_tab[i].edge_no, scan_tab[i].an, scan_tab[i].seg,
                     scan_tab[i].dp, scan_tab[i].idx);
    endtask

    task automatic restart_scan(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] mask);
        bus.enable = 1'b0;
        tick();
        chk("disabled", dut_out(), {4'hF, 7'h7F, 1'b1, 2'd0});
        bus.digits     = d;
        bus.dp_en      = dp;
        bus.blank_mask = mask;
        bus.enable     = 1'b1;
        ecount = 0;
    endtask

    initial begin
        scan_tab[0]  = '{1,  4'b1111, 7'h7F,      1'b1, 2'd0};
        scan_tab[1]  = '{2,  4'b1111, 7'h7F,      1'b1, 2'd0};
        scan_tab[2]  = '{3,  4'b1110, 7'b1111001, 1'b1, 2'd0};
        scan_tab[3]  = '{8,  4'b1110, 7'b1111001, 1'b1, 2'd0};
        scan_tab[4]  = '{9,  4'b1111, 7'h7F,      1'b1, 2'd1};
        scan_tab[5]  = '{11, 4'b1101, 7'b0100100, 1'b1, 2'd1};
        scan_tab[6]  = '{16, 4'b1101, 7'b0100100, 1'b1, 2'd1};
        scan_tab[7]  = '{19, 4'b1011, 7'b0110000, 1'b1, 2'd2};
        scan_tab[8]  = '{27, 4'b0111, 7'b0011001, 1'b1, 2'd3};
        scan_tab[9]  = '{32, 4'b0111, 7'b0011001, 1'b1, 2'd3};
        scan_tab[10] = '{33, 4'b1111, 7'h7F,      1'b1, 2'd0};
        scan_tab[11] = '{35, 4'b1110, 7'b1111001, 1'b1, 2'd0};

        bus.enable = 1'b0;
        bus.digits = 16'h0;
        bus.dp_en = 4'h0;
        bus.blank_mask = 4'h0;

        // Reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            bus.enable     = 1'b1;
            bus.digits     = 16'($urandom);
            bus.dp_en      = 4'($urandom);
            bus.blank_mask = 4'($urandom);
            tick();
            chk("reset_hold", dut_out(), {4'hF, 7'h7F, 1'b1, 2'd0});
        end

        // Basic scan with wrap
        bus.digits = 16'h4321;
        bus.dp_en = 4'h0;
        bus.blank_mask = 4'h0;
        reset_n = 1'b1;
        ecount = 0;
        run_scan_table();

        // Masked slot keeps its timing
        restart_scan(16'hFEDC, 4'h0, 4'b0100);
        check_at("mask_slot2", 20, 4'b1111, 7'h7F, 1'b1, 2'd2);
        check_at("mask_s3_blank", 26, 4'b1111, 7'h7F, 1'b1, 2'd3);
        check_at("mask_s3_F", 27, 4'b0111, 7'b0001110, 1'b1, 2'd3);

        // Decimal point and letters
        restart_scan(16'hA0B0, 4'b0010, 4'h0);
        check_at("dp_s0", 3, 4'b1110, 7'b1000000, 1'b1, 2'd0);
        check_at("dp_s1_b", 11, 4'b1101, 7'b0000011, 1'b0, 2'd1);
        check_at("dp_s2", 19, 4'b1011, 7'b1000000, 1'b1, 2'd2);
        check_at("dp_s3_A", 27, 4'b0111, 7'b0001000, 1'b1, 2'd3);

        // Enable drop at presc=5 in slot 2
        restart_scan(16'h4321, 4'h0, 4'h0);
        run_to(21);
        bus.enable = 1'b0;
        tick();
        chk("en_drop", dut_out(), {4'b1111, 7'h7F, 1'b1, 2'd0});
        bus.enable = 1'b1;
        ecount = 0;
        check_at("reen_b1", 1, 4'b1111, 7'h7F, 1'b1, 2'd0);
        check_at("reen_b2", 2, 4'b1111, 7'h7F, 1'b1, 2'd0);
        check_at("reen_d0", 3, 4'b1110, 7'b1111001, 1'b1, 2'd0);

        // Async reset mid-slot 3
        check_at("pre_reset", 28, 4'b0111, 7'b0011001, 1'b1, 2'd3);
        #1 reset_n = 1'b0;
        #1 chk("async_reset", dut_out(), {4'hF, 7'h7F, 1'b1, 2'd0});
        tick();
        tick();
        reset_n = 1'b1;
        ecount = 0;
        run_scan_table();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
